mux4_scan_ctrl: RTL and testbench
=================================

# mux4_scan_ctrl

Round-robin scan controller that sits directly upstream of the 4:1 single-bit mux. It drives the mux select lines, dwells a programmable number of cycles on each enabled channel, and samples the mux output. It assembles the four sampled bits into a frame, which it hands downstream through a valid/ready handshake.

## Interface
- `DWELL`, default 4: cycles spent on each enabled channel; legal range 1..255.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous reset, active-low. It is sampled on the `clk` rising edge.
- `start` in 1: level-sampled request to begin one scan. Honoured only in IDLE.
- `en_mask` in 4: per-channel enable, bit c = channel c. Latched when `start` is accepted.
- `y` in 1: output of the 4:1 mux, i.e. `i[s]`.
- `s` out 2: mux select, driven from a register.
- `frame` out 4: captured bits; bit c = `y` sampled while `s`==c. Disabled channels read 0.
- `frame_valid` out 1: `frame` is stable and available.
- `frame_ready` in 1: downstream accepts `frame`.
- `busy` out 1: high in SCAN and HOLD.

## Operation
- **Reset values:** while `rst_n`=0 at an edge, all outputs and state return to reset values on that edge: `s`=0, `frame`=0, `frame_valid`=0, `busy`=0, state=IDLE, dwell counter=0, latched mask=0, shadow frame=0. This applies at any point, including mid-scan or in HOLD.
- **IDLE:**
  - `start`=1 and `en_mask`!=0 → latch `en_mask`, clear the shadow frame, load `s` with the lowest enabled channel, load the counter with `DWELL`-1, and go to SCAN.
  - `start`=1 with `en_mask`=0 is ignored; the block stays in IDLE.
- **SCAN:**
  - `s` holds the current channel; the counter decrements each cycle.
  - When the counter is 0:
    - Capture `y` into shadow bit `s`.
    - If a higher enabled channel exists, load `s` with the next higher enabled channel and reload the counter with `DWELL`-1. Disabled channels consume zero cycles.
    - Otherwise, copy the shadow frame plus the just-captured bit into `frame`, set `frame_valid`=1, and go to HOLD.
- **HOLD:**
  - `frame` and `frame_valid` stay stable while `frame_ready`=0.
  - `frame_valid`=1 with `frame_ready`=1 at an edge completes the transfer: `frame_valid`=0, state=IDLE, `busy`=0 on that edge.
  - `frame` retains its value after the transfer until the next frame is loaded.
- **Don't-care and ignored inputs:**
  - `start` is ignored in SCAN and HOLD; it is not queued.
  - Changes to `en_mask` after acceptance have no effect on the current scan.
  - `frame_ready` is don't-care outside HOLD.
- **Select values:** `s` only ever takes enabled channel values during SCAN. In IDLE it retains its last value; after reset it is 0.

## Timing
- **Scan sequence:** `start` accepted at the edge ending cycle 0. Then:
  - `busy`=1 and `s` = first enabled channel from cycle 1.
  - Each enabled channel occupies exactly `DWELL` consecutive cycles.
  - `y` is sampled on the edge ending the last cycle of each dwell.
- **Latency:** with N enabled channels, `frame_valid` rises at cycle 1+N·`DWELL`. Minimum is 2, for N=1 and `DWELL`=1.
- **Mux path:** the mux is combinational, so `y` is valid in the same cycle as `s`. There are no additional settle cycles beyond `DWELL`.
- **Throughput and handshake:**
  - `frame_valid` deasserts on the edge where `frame_ready`=1 is sampled.
  - The earliest restart is `start` sampled in the first IDLE cycle after the transfer.
  - Maximum throughput is one frame per N·`DWELL`+2 cycles.
- **Simultaneous events:** `rst_n`=0 overrides everything, including a completing handshake or `start`.

## Test plan
- **Reset mid-scan:** `DWELL`=4, `en_mask`=4'b1111; assert `rst_n`=0 for 2 cycles during cycle 6 → at the next edge `s`=0, `frame`=0, `frame_valid`=0, `busy`=0. After release, no activity until a new `start`.
- **Full scan:** `DWELL`=4, `en_mask`=4'b1111, mux data `i`=4'b1010, `frame_ready`=1, `start` at cycle 0 → `s` is 0, 1, 2, 3 during cycles 1–4, 5–8, 9–12 and 13–16 respectively. `frame_valid`=1 in cycle 17 with `frame`=4'b1010, and `busy`=0 in cycle 18.
- **Mask skip:** `DWELL`=4, `en_mask`=4'b0101, `i`=4'b1111 → `s`=0 in cycles 1–4 and `s`=2 in cycles 5–8. `s` is never 1 or 3. `frame_valid` in cycle 9 with `frame`=4'b0101.
- **Backpressure:** after a frame, hold `frame_ready`=0 for 10 cycles and pulse `start` and toggle `en_mask` during that time → `frame_valid`=1 and `frame` unchanged throughout, with no new scan. Raise `frame_ready` → `frame_valid`=0 and `busy`=0 on the next edge.
- **Ignored start:** `start` with `en_mask`=0 → `busy` stays 0. `start` re-asserted during SCAN → the scan length is unchanged and no second frame appears.
- **Single channel, minimum latency:** `DWELL`=1, `en_mask`=4'b1000, `i`=4'b1000 → `s`=3 in cycle 1, `frame_valid` in cycle 2, `frame`=4'b1000.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl
//   Round-robin scan controller for a 4:1 single-bit mux. It steps the mux
//   select over the enabled channels, dwelling DWELL cycles on each, samples
//   the mux output on the last cycle of each dwell, and hands the assembled
//   4-bit frame downstream over a valid/ready handshake.
//
//   State table
//     state   | meaning
//     IDLE    | waiting for start with a non-zero en_mask
//     SCAN    | s on current channel, counter running down to the sample cycle
//     HOLD    | frame presented, waiting for frame_ready
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        scan request, honoured only in IDLE
//   en_mask[3:0] per-channel enable, latched when start is accepted
//   y            mux output (i[s])
//   s[1:0]       registered mux select
//   frame[3:0]   captured bits, bit c = y sampled while s == c
//   frame_valid  frame available downstream
//   frame_ready  downstream accepts frame
//   busy         high in SCAN and HOLD
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] en_mask,
    input  logic       y,
    output logic [1:0] s,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic [3:0] frame_q, frame_d;
    logic       frame_valid_q, frame_valid_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] shadow_q, shadow_d;

    logic [3:0] captured;
    logic [2:0] nxt;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (m[c]) lowest_ch = 2'(c);
        end
    endfunction

    // {found, channel}: the lowest enabled channel above cur, so disabled
    // channels are skipped without spending any cycles on them.
    function automatic logic [2:0] next_up(input logic [3:0] m, input logic [1:0] cur);
        next_up = 3'b000;
        for (int c = 3; c >= 0; c--) begin
            if (m[c] && (c > int'(cur))) next_up = {1'b1, 2'(c)};
        end
    endfunction

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        busy_d        = busy_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        captured      = shadow_q | ({3'b000, y} << s_q);
        nxt           = next_up(mask_q, s_q);

        case (state_q)
            ST_IDLE: begin
                if (start && (en_mask != 4'b0000)) begin
                    mask_d   = en_mask;
                    shadow_d = 4'b0000;
                    s_d      = lowest_ch(en_mask);
                    cnt_d    = DWELL_M1;
                    busy_d   = 1'b1;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    shadow_d = captured;
                    if (nxt[2]) begin
                        s_d   = nxt[1:0];
                        cnt_d = DWELL_M1;
                    end else begin
                        frame_d       = captured;
                        frame_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    frame_valid_d = 1'b0;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            s_q           <= 2'd0;
            frame_q       <= 4'd0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= 8'd0;
            mask_q        <= 4'd0;
            shadow_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
        end
    end

    assign s           = s_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Testbench for mux4_scan_ctrl: one instance with DWELL=4 and one with
// DWELL=1 share the control stimulus; each has its own mux data word.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] en_mask = 4'd0;
    logic       frame_ready = 1'b0;
    logic [3:0] i4 = 4'd0;
    logic [3:0] i1 = 4'd0;

    logic [1:0] s4, s1;
    logic [3:0] frame4, frame1;
    logic       fv4, fv1, busy4, busy1;
    logic       y4, y1;

    assign y4 = i4[s4];
    assign y1 = i1[s1];

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.DWELL(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .en_mask(en_mask), .y(y4),
        .s(s4), .frame(frame4), .frame_valid(fv4), .frame_ready(frame_ready), .busy(busy4)
    );

    mux4_scan_ctrl #(.DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .en_mask(en_mask), .y(y1),
        .s(s1), .frame(frame1), .frame_valid(fv1), .frame_ready(frame_ready), .busy(busy1)
    );

    // One record per cycle: inputs driven in that cycle, and the outputs
    // expected at the start of that cycle (i.e. after the previous edge).
    typedef struct packed {
        logic       rst_n;
        logic       start;
        logic [3:0] en_mask;
        logic       frame_ready;
        logic [3:0] i;
        logic       chk;
        logic [1:0] exp_s;
        logic       exp_fv;
        logic       exp_busy;
        logic [3:0] exp_frame;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic push(input logic r, input logic st, input logic [3:0] m,
                        input logic rdy, input logic [3:0] iv, input logic ck,
                        input logic [1:0] es, input logic efv, input logic eb,
                        input logic [3:0] ef);
        vec_t v;
        v.rst_n = r; v.start = st; v.en_mask = m; v.frame_ready = rdy; v.i = iv;
        v.chk = ck; v.exp_s = es; v.exp_fv = efv; v.exp_busy = eb; v.exp_frame = ef;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        push(0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 0, 0, 4'h0);
        push(0, 0, 4'h0, 0, 4'h0, 0, 2'd0, 0, 0, 4'h0);
        // full scan, mask 1111, i = 1010
        push(1, 1, 4'hF, 1, 4'hA, 1, 2'd0, 0, 0, 4'h0);
        for (int k = 1; k <= 16; k++)
            push(1, 0, 4'hF, 1, 4'hA, 1, 2'((k - 1) / 4), 0, 1, 4'h0);
        push(1, 0, 4'hF, 1, 4'hA, 1, 2'd3, 1, 1, 4'hA);
        // first IDLE cycle after transfer: restart with mask 0101, i = 1111
        push(1, 1, 4'h5, 0, 4'hF, 1, 2'd3, 0, 0, 4'hA);
        push(1, 0, 4'h5, 0, 4'hF, 1, 2'd0, 0, 1, 4'hA);
        // en_mask changes mid-scan must not matter
        for (int k = 2; k <= 4; k++)
            push(1, 0, 4'hA, 0, 4'hF, 1, 2'd0, 0, 1, 4'hA);
        for (int k = 5; k <= 8; k++)
            push(1, 0, 4'hA, 0, 4'hF, 1, 2'd2, 0, 1, 4'hA);
        // backpressure: 10 cycles of frame_ready=0 with start pulses and mask toggles
        for (int k = 9; k <= 18; k++)
            push(1, k[0], k[0] ? 4'hF : 4'h0, 0, 4'hF, 1, 2'd2, 1, 1, 4'h5);
        push(1, 0, 4'h5, 1, 4'hF, 1, 2'd2, 1, 1, 4'h5);
        // start with empty mask is ignored
        push(1, 1, 4'h0, 0, 4'hF, 1, 2'd2, 0, 0, 4'h5);
        push(1, 1, 4'h0, 0, 4'hF, 1, 2'd2, 0, 0, 4'h5);
        push(1, 1, 4'h0, 0, 4'hF, 1, 2'd2, 0, 0, 4'h5);
        push(1, 0, 4'h0, 0, 4'hF, 1, 2'd2, 0, 0, 4'h5);

        foreach (vecs[n]) begin
            if (vecs[n].chk) begin
                check($sformatf("vec%0d s", n), {2'b00, s4}, {2'b00, vecs[n].exp_s});
                check($sformatf("vec%0d frame_valid", n), {3'b000, fv4}, {3'b000, vecs[n].exp_fv});
                check($sformatf("vec%0d busy", n), {3'b000, busy4}, {3'b000, vecs[n].exp_busy});
                check($sformatf("vec%0d frame", n), frame4, vecs[n].exp_frame);
            end
            rst_n       = vecs[n].rst_n;
            start       = vecs[n].start;
            en_mask     = vecs[n].en_mask;
            frame_ready = vecs[n].frame_ready;
            i4          = vecs[n].i;
            tick();
        end

        // reset mid-scan: start at cycle 0, rst_n low during cycles 6 and 7
        start = 1; en_mask = 4'hF; i4 = 4'hA; frame_ready = 0;
        tick();
        start = 0;
        repeat (5) tick();
        check("midscan pre s", {2'b00, s4}, 4'd1);
        check("midscan pre busy", {3'b000, busy4}, 4'd1);
        rst_n = 0;
        tick();
        check("midscan rst s", {2'b00, s4}, 4'd0);
        check("midscan rst frame", frame4, 4'h0);
        check("midscan rst frame_valid", {3'b000, fv4}, 4'd0);
        check("midscan rst busy", {3'b000, busy4}, 4'd0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("post-reset busy", {3'b000, busy4}, 4'd0);
            check("post-reset frame_valid", {3'b000, fv4}, 4'd0);
        end

        // start held through the whole scan: length unchanged, one frame only
        start = 1; en_mask = 4'h3; i4 = 4'b0010; frame_ready = 0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("heldstart c%0d frame_valid", k), {3'b000, fv4}, 4'd0);
            check($sformatf("heldstart c%0d busy", k), {3'b000, busy4}, 4'd1);
            tick();
        end
        check("heldstart c9 frame_valid", {3'b000, fv4}, 4'd1);
        check("heldstart c9 frame", frame4, 4'b0010);
        start = 0; frame_ready = 1;
        tick();
        check("heldstart c10 frame_valid", {3'b000, fv4}, 4'd0);
        check("heldstart c10 busy", {3'b000, busy4}, 4'd0);
        frame_ready = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("no second frame valid", {3'b000, fv4}, 4'd0);
            check("no second frame busy", {3'b000, busy4}, 4'd0);
        end

        // DWELL=1 single channel, minimum latency
        rst_n = 0;
        tick();
        rst_n = 1;
        start = 1; en_mask = 4'b1000; i1 = 4'b1000; frame_ready = 0;
        tick();
        check("min c1 s", {2'b00, s1}, 4'd3);
        check("min c1 busy", {3'b000, busy1}, 4'd1);
        check("min c1 frame_valid", {3'b000, fv1}, 4'd0);
        start = 0;
        tick();
        check("min c2 frame_valid", {3'b000, fv1}, 4'd1);
        check("min c2 frame", frame1, 4'b1000);
        frame_ready = 1;
        tick();
        check("min c3 frame_valid", {3'b000, fv1}, 4'd0);
        check("min c3 busy", {3'b000, busy1}, 4'd0);
        check("min c3 frame kept", frame1, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
